// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter sequencer: architectural modes, FSM states, digit count.
package counter_ctrl_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;

  // State encoding reuses the mode encoding so the mode output is a plain copy outside LOAD.
  typedef enum logic [1:0] {
    ST_HOLD = MODE_HOLD,
    ST_UP   = MODE_UP,
    ST_DOWN = MODE_DOWN,
    ST_LOAD = 2'b11
  } state_t;

  localparam int NUM_DIGITS = 4;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_HOLD: next_mode = MODE_UP;
      MODE_UP:   next_mode = MODE_DOWN;
      default:   next_mode = MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// Free-running prescaler 0..DIV-1; wrap is a combinational compare of the registered count.
// Runs unconditionally out of reset; no stall input.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic clr,
  output logic wrap
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap  = (cnt_q == W'(DIV - 1));
  assign cnt_d = wrap ? '0 : cnt_q + W'(1);

  always_ff @(posedge clk) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter_ctrl.sv
// Mode FSM with load insertion, button edge detectors, step strobe and digit-scan select.
// Single clock; all outputs registered or decoded from registers, one-cycle decision latency.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int SCAN_HZ = 400
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_db,
  input  logic       load_db,
  input  logic       enable,
  output logic [1:0] mode,
  output logic       cnt_tick,
  output logic       cnt_up,
  output logic       cnt_load,
  output logic [1:0] sel
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

  state_t     state_q, state_d;
  logic [1:0] ret_q, ret_d;
  logic       cnt_up_q, cnt_up_d;
  logic       cnt_tick_q, cnt_tick_d;
  logic [1:0] sel_q;
  logic       btn_prev_q, load_prev_q;
  logic       btn_rise, load_rise;
  logic       step_wrap, scan_wrap;

  tick_gen #(.DIV(TICK_DIV)) u_step_gen (.clk(clk), .clr(clr), .wrap(step_wrap));
  tick_gen #(.DIV(SCAN_DIV)) u_scan_gen (.clk(clk), .clr(clr), .wrap(scan_wrap));

  assign btn_rise  = btn_db & ~btn_prev_q;
  assign load_rise = load_db & ~load_prev_q;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_up_d = cnt_up_q;
    // LOAD always lasts one cycle; any button activity during it is dropped.
    if (state_q == ST_LOAD) begin
      state_d = state_t'(ret_q);
    end else if (load_rise) begin
      state_d = ST_LOAD;
      ret_d   = state_q;
    end else if (btn_rise) begin
      state_d = state_t'(next_mode(state_q));
    end
    if (state_d == ST_UP)        cnt_up_d = 1'b1;
    else if (state_d == ST_DOWN) cnt_up_d = 1'b0;
  end

  // A wrap masked by enable, HOLD or LOAD is simply lost.
  assign cnt_tick_d = step_wrap & enable & ((state_q == ST_UP) | (state_q == ST_DOWN));

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_HOLD;
      ret_q       <= MODE_HOLD;
      cnt_up_q    <= 1'b1;
      cnt_tick_q  <= 1'b0;
      sel_q       <= '0;
      btn_prev_q  <= 1'b1;
      load_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_up_q    <= cnt_up_d;
      cnt_tick_q  <= cnt_tick_d;
      if (scan_wrap) sel_q <= sel_q + 2'd1;
      btn_prev_q  <= btn_db;
      load_prev_q <= load_db;
    end
  end

  assign mode     = (state_q == ST_LOAD) ? ret_q : state_q;
  assign cnt_load = (state_q == ST_LOAD);
  assign cnt_up   = cnt_up_q;
  assign cnt_tick = cnt_tick_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized and directed bench for counter_ctrl against a cycle-count based reference model.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       btn_db = 1'b0;
  logic       load_db = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode;
  logic       cnt_tick;
  logic       cnt_up;
  logic       cnt_load;
  logic [1:0] sel;

  always #5 clk = ~clk;

  counter_ctrl #(.CLK_HZ(16), .TICK_HZ(1), .SCAN_HZ(4)) dut (
    .clk(clk), .clr(clr), .btn_db(btn_db), .load_db(load_db), .enable(enable),
    .mode(mode), .cnt_tick(cnt_tick), .cnt_up(cnt_up), .cnt_load(cnt_load), .sel(sel)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: mode as 0/1/2, plus a one-cycle load flag; timing from edges since reset.
  int m_mode = 0, m_ret = 0, m_n = 0;
  bit m_load = 0, m_up = 1, m_tick = 0, m_bprev = 1, m_lprev = 1;
  int m_sel = 0;

  task automatic cycle();
    bit brise, lrise, tick_new;
    @(posedge clk);
    if (!clr) begin
      m_mode = 0; m_ret = 0; m_load = 0; m_up = 1; m_tick = 0;
      m_bprev = 1; m_lprev = 1; m_n = 0; m_sel = 0;
    end else begin
      brise    = btn_db && !m_bprev;
      lrise    = load_db && !m_lprev;
      tick_new = ((m_n % 16) == 15) && enable && (m_mode != 0) && !m_load;
      if (m_load) m_load = 0;
      else if (lrise) m_load = 1;
      else if (brise) m_mode = (m_mode + 1) % 3;
      if (m_mode == 1) m_up = 1;
      else if (m_mode == 2) m_up = 0;
      m_tick  = tick_new;
      m_n++;
      m_sel   = (m_n / 4) % 4;
      m_bprev = btn_db;
      m_lprev = load_db;
    end
    #1;
    chk("mode", mode, m_mode);
    chk("cnt_load", cnt_load, m_load);
    chk("cnt_up", cnt_up, m_up);
    chk("cnt_tick", cnt_tick, m_tick);
    chk("sel", sel, m_sel);
  endtask

  task automatic press();
    btn_db = 1'b1; cycle();
    btn_db = 1'b0; repeat (4) cycle();
  endtask

  int ticks;
  int last_tick;
  int sel_tab[5] = '{1, 2, 3, 0, 1};
  int mode_tab[3] = '{1, 2, 0};
  int up_tab[3] = '{1, 0, 0};

  initial begin
    // Reset with the mode button held: no edge on release.
    clr = 1'b0; btn_db = 1'b1;
    repeat (3) cycle();
    chk("rst_mode", mode, 0);
    chk("rst_sel", sel, 0);
    chk("rst_strobes", {cnt_tick, cnt_load}, 0);
    clr = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (c % 4 == 0) chk("scan_sel", sel, sel_tab[c / 4 - 1]);
    end
    chk("held_btn_mode", mode, 0);
    btn_db = 1'b0;

    // Reset in the middle of scanning.
    clr = 1'b0; cycle(); clr = 1'b1;
    repeat (10) cycle();
    clr = 1'b0; cycle();
    chk("midrst_sel", sel, 0);
    clr = 1'b1; cycle();

    // Mode cycling.
    for (int i = 0; i < 3; i++) begin
      btn_db = 1'b1; cycle();
      chk("cycle_mode", mode, mode_tab[i]);
      chk("cycle_up", cnt_up, up_tab[i]);
      btn_db = 1'b0; repeat (4) cycle();
    end

    // Ticks in UP with enable: one cycle wide, 16 apart.
    press();
    enable = 1'b1;
    ticks = 0; last_tick = -1;
    for (int c = 0; c < 50; c++) begin
      cycle();
      if (cnt_tick) begin
        if (last_tick >= 0) chk("tick_period", c - last_tick, 16);
        last_tick = c; ticks++;
      end
    end
    chk("tick_count_en", ticks, 3);
    enable = 1'b0; ticks = 0;
    repeat (40) begin cycle(); ticks += cnt_tick; end
    chk("tick_count_dis", ticks, 0);
    enable = 1'b1;
    press(); press();
    chk("hold_mode", mode, 0);
    ticks = 0;
    repeat (40) begin cycle(); ticks += cnt_tick; end
    chk("tick_count_hold", ticks, 0);

    // Load wins over a simultaneous mode press.
    press(); press();
    chk("down_mode", mode, 2);
    btn_db = 1'b1; load_db = 1'b1; cycle();
    chk("prio_load", cnt_load, 1);
    chk("prio_mode", mode, 2);
    btn_db = 1'b0; load_db = 1'b0; cycle();
    chk("prio_load_end", cnt_load, 0);
    chk("prio_mode_after", mode, 2);
    repeat (3) cycle();

    // LOAD cycle coinciding with a step wrap swallows that tick.
    for (int g = 0; g < 20 && (m_n % 16) != 14; g++) cycle();
    chk("collide_align", m_n % 16, 14);
    load_db = 1'b1; cycle();
    chk("collide_load", cnt_load, 1);
    load_db = 1'b0; cycle();
    chk("collide_tick", cnt_tick, 0);
    ticks = 0;
    for (int c = 1; c <= 16; c++) begin
      cycle(); ticks += cnt_tick;
      if (c == 16) chk("collide_next_tick", cnt_tick, 1);
    end
    chk("collide_tick_count", ticks, 1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      btn_db  = ($urandom_range(0, 5) == 0) ? ~btn_db : btn_db;
      load_db = ($urandom_range(0, 9) == 0) ? ~load_db : load_db;
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      clr = ($urandom_range(0, 150) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Single-clock sequencer for the counter/seven-segment datapath. It turns the debounced mode and load buttons into a registered mode state machine. It also generates the counter step strobe and the digit-scan select from the system clock using internal prescalers, so the datapath needs no divided clocks. It sits between the debounce instances and the counter, mux4to1 and sev_scan blocks, and replaces the divided clocks that drive them today.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- TICK_HZ, 1: counter step rate; TICK_DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- SCAN_HZ, 400: digit advance rate; SCAN_DIV = CLK_HZ/SCAN_HZ, must be ≥ 2.
- clk  in  1  system clock; the only clock.
- clr  in  1  reset, synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- btn_db  in  1  debounced mode button, level.
- load_db  in  1  debounced load button, level.
- enable  in  1  count enable switch, level.
- mode  out  2  current mode: HOLD=00, UP=01, DOWN=10.
- cnt_tick  out  1  one-cycle counter step strobe.
- cnt_up  out  1  count direction: 1 = up, 0 = down.
- cnt_load  out  1  one-cycle load strobe; the counter captures data on it.
- sel  out  2  digit select for the mux and the anode decoder.

## Operation
- Edge detection:
  - btn_db and load_db each have a registered previous-value flop.
  - rise = input & ~prev.
  - Both prev flops reset to 1, so a button held through reset release produces no edge.
- Mode FSM: states HOLD, UP, DOWN, LOAD.
  - A btn rise advances the mode HOLD→UP→DOWN→HOLD.
  - A load rise in any state enters LOAD for exactly one cycle. The current mode is saved in ret_mode, and LOAD returns to ret_mode unconditionally on the next cycle.
  - A btn rise during the LOAD cycle is discarded.
  - A btn rise and a load rise in the same cycle: load wins and the btn rise is discarded.
- mode output:
  - Shows the architectural mode (HOLD/UP/DOWN).
  - During LOAD it shows ret_mode and never shows 11.
- cnt_up: 1 in UP, 0 in DOWN, holds its last value in HOLD and LOAD.
- cnt_load: 1 exactly in the LOAD cycle.
- Step prescaler:
  - Free-running counter 0..TICK_DIV-1, with wrap = (count == TICK_DIV-1).
  - It runs regardless of mode and enable.
  - cnt_tick = registered (wrap & enable & mode∈{UP,DOWN} & state≠LOAD).
  - A masked wrap is lost, not deferred.
- Scan prescaler:
  - Same structure with SCAN_DIV.
  - sel increments modulo 4 (3→0) on each wrap.
  - sel is independent of the FSM.
- Width rule: each prescaler is $clog2(DIV) bits wide and compares against DIV-1; there is no overflow path.

## Timing
- Reset values (first edge with clr=0 and every edge while it is held):
  - mode=HOLD, ret_mode=HOLD, cnt_up=1.
  - cnt_tick=0, cnt_load=0, sel=0.
  - Both prescalers 0; prev flops 1.
- Reset mid-operation: the next edge forces all of the above. A pending LOAD or tick is cancelled.
- Mode latency:
  - btn_db rises before edge k.
  - mode and cnt_up change after edge k (1 cycle).
- Load latency:
  - load_db rises before edge k.
  - cnt_load is high from edge k to edge k+1, then low.
- Step timing:
  - The first prescaler wrap after reset release occurs TICK_DIV-1 cycles later.
  - cnt_tick appears one cycle after the wrap and then repeats every TICK_DIV cycles.
  - Each pulse is high for exactly one cycle.
- Enable timing: enable is sampled in the wrap cycle only.
- Scan timing: sel advances every SCAN_DIV cycles; the first change comes SCAN_DIV cycles after reset release.

## Structure
- Package counter_ctrl_pkg:
  - Mode encoding constants MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10.
  - Internal state constant ST_LOAD.
  - Digit count NUM_DIGITS=4.
- Sub-module tick_gen:
  - Parameter DIV; inputs clk, clr; output wrap (combinational compare of a registered count).
  - Instantiated twice, once for the step prescaler and once for the scan prescaler.
- The FSM, edge detectors and sel counter live in counter_ctrl.

## Test plan
Test parameters: CLK_HZ=16, TICK_HZ=1 (TICK_DIV=16), SCAN_HZ=4 (SCAN_DIV=4).
- Reset:
  - Hold clr=0 for 3 cycles with btn_db=1.
  - Required: mode=00, sel=0, all strobes 0.
  - Release reset with btn_db still 1: mode stays 00, because no edge is produced.
- Mode cycling:
  - Apply three btn_db rises, 5 cycles apart.
  - Required: mode goes 01 → 10 → 00, each change one cycle after its rise.
  - Required: cnt_up goes 1 → 0 → 0.
- Ticks:
  - enable=1, mode UP.
  - Required: cnt_tick pulses one cycle wide, exactly 16 cycles apart.
  - Set enable=0: no pulses.
  - Set mode HOLD with enable=1: no pulses.
- Load priority:
  - In DOWN, raise load_db and btn_db in the same cycle.
  - Required: cnt_load high for 1 cycle, mode stays 10, no mode advance.
- Load/tick collision:
  - Align a load rise so that LOAD coincides with a prescaler wrap.
  - Required: no cnt_tick for that wrap; the next tick comes 16 cycles later.
- Scan:
  - Run 20 cycles from reset.
  - Required: sel = 1, 2, 3, 0, 1 at cycles 4, 8, 12, 16, 20.
  - Assert clr=0 at cycle 10: sel=0 on the next edge.
